// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: drives pclk/href/vsync/data with QVGA-style RGB565 timing and test patterns.
// Latency: outputs are registered; each byte slot's values appear on the pclk falling edge that opens the slot.
// Backpressure: none; the stream is free-running while run=1 and finishes the current frame when run drops.
// Optional build macro OV7670_STREAM_SCROLL_EN: patterns 0-2 scroll horizontally 2 px per completed frame.
module ov7670_stream_gen #(
    parameter int DIV      = 2,
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 17,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] pattern_sel,
    output logic       ov_pclk,
    output logic       ov_href,
    output logic       ov_vsync,
    output logic [7:0] ov_data,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int BCW        = $clog2(LINE_BYTES);
    localparam int DW         = $clog2(DIV);
    localparam int LCW        = 10;

    localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF  = DW'(DIV / 2);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(LINE_BYTES - 1);
    localparam logic [BCW-1:0] HREF_END  = BCW'(2 * H_ACTIVE);
    localparam logic [LCW-1:0] VS_LAST   = LCW'(V_SYNC - 1);
    localparam logic [LCW-1:0] VBP_LAST  = LCW'(V_BP - 1);
    localparam logic [LCW-1:0] VA_LAST   = LCW'(V_ACTIVE - 1);
    localparam logic [LCW-1:0] VFP_LAST  = LCW'(V_FP - 1);
    localparam logic [8:0]     BAR_LAST  = 9'(H_ACTIVE / 8 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBP    = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFP    = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [DW-1:0]  div_cnt_q, div_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [LCW-1:0] line_cnt_q, line_cnt_d;
    logic [1:0]     pat_q, pat_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    logic [8:0]     bar_px_q, bar_px_d;
    logic           pclk_q, pclk_d;
    logic           href_q, href_d;
    logic           vsync_q, vsync_d;
    logic [7:0]     data_q, data_d;
    logic           busy_q, busy_d;

    logic           slot_end;
    logic           in_href;
    logic [LCW-1:0] line_last;
    logic [8:0]     x_raw;
    logic [8:0]     x;
    logic [15:0]    bar_pix;
    logic [15:0]    pix;
    logic [7:0]     pix_byte;
    logic [2:0]     bar_start;
    logic [8:0]     px_start;

`ifdef OV7670_STREAM_SCROLL_EN
    localparam logic [8:0] H_LAST9 = 9'(H_ACTIVE - 1);
    localparam logic [9:0] H_ACT10 = 10'(H_ACTIVE);

    logic [8:0] scroll_x_q, scroll_x_d;
    logic [2:0] scroll_bar_q, scroll_bar_d;
    logic [8:0] scroll_px_q, scroll_px_d;
    logic [8:0] sx1, sx2, spx1, spx2;
    logic [2:0] sbar1, sbar2;
    logic [9:0] x_sum;

    // Scroll origin for the next frame: two pixels further on, kept both as x and as bar/offset.
    always_comb begin
        sx1   = (scroll_x_q == H_LAST9) ? 9'd0 : scroll_x_q + 9'd1;
        sx2   = (sx1 == H_LAST9) ? 9'd0 : sx1 + 9'd1;
        spx1  = (scroll_px_q == BAR_LAST) ? 9'd0 : scroll_px_q + 9'd1;
        sbar1 = (scroll_px_q == BAR_LAST) ? scroll_bar_q + 3'd1 : scroll_bar_q;
        spx2  = (spx1 == BAR_LAST) ? 9'd0 : spx1 + 9'd1;
        sbar2 = (spx1 == BAR_LAST) ? sbar1 + 3'd1 : sbar1;
    end

    assign bar_start = scroll_bar_q;
    assign px_start  = scroll_px_q;
`else
    assign bar_start = 3'd0;
    assign px_start  = 9'd0;
`endif

    assign slot_end = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
    assign in_href  = (state_q == S_ACTIVE) && (byte_cnt_q < HREF_END);

    // Pixel value and byte for the slot currently addressed by the counters.
    always_comb begin
        x_raw = 9'(byte_cnt_q >> 1);
`ifdef OV7670_STREAM_SCROLL_EN
        x_sum = {1'b0, x_raw} + {1'b0, scroll_x_q};
        x     = (x_sum >= H_ACT10) ? 9'(x_sum - H_ACT10) : x_sum[8:0];
`else
        x     = x_raw;
`endif
        case (bar_idx_q)
            3'd0:    bar_pix = 16'hFFFF;
            3'd1:    bar_pix = 16'hFFE0;
            3'd2:    bar_pix = 16'h07FF;
            3'd3:    bar_pix = 16'h07E0;
            3'd4:    bar_pix = 16'hF81F;
            3'd5:    bar_pix = 16'hF800;
            3'd6:    bar_pix = 16'h001F;
            default: bar_pix = 16'h0000;
        endcase
        case (pat_q)
            2'd0:    pix = bar_pix;
            2'd1:    pix = {x[8:4], line_cnt_q[7:2], x[4:0]};
            2'd2:    pix = (x[4] ^ line_cnt_q[4]) ? 16'hFFFF : 16'h0000;
            default: pix = {frame_cnt_q, frame_cnt_q};
        endcase
        pix_byte = byte_cnt_q[0] ? pix[7:0] : pix[15:8];
    end

    // Line count limit of the current frame phase.
    always_comb begin
        case (state_q)
            S_VSYNC:  line_last = VS_LAST;
            S_VBP:    line_last = VBP_LAST;
            S_ACTIVE: line_last = VA_LAST;
            S_VFP:    line_last = VFP_LAST;
            default:  line_last = '0;
        endcase
    end

    // Frame FSM, slot/line counters and next values of the registered bus outputs.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        line_cnt_d  = line_cnt_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        bar_idx_d   = bar_idx_q;
        bar_px_d    = bar_px_q;
        href_d      = href_q;
        vsync_d     = vsync_q;
        data_d      = data_q;
`ifdef OV7670_STREAM_SCROLL_EN
        scroll_x_d   = scroll_x_q;
        scroll_bar_d = scroll_bar_q;
        scroll_px_d  = scroll_px_q;
`endif
        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
            href_d    = 1'b0;
            vsync_d   = 1'b0;
            data_d    = 8'h00;
            if (run) begin
                state_d    = S_VSYNC;
                byte_cnt_d = '0;
                line_cnt_d = '0;
                pat_d      = pattern_sel;
            end
        end else begin
            div_cnt_d = slot_end ? '0 : div_cnt_q + DW'(1);
            if (slot_end) begin
                vsync_d = (state_q == S_VSYNC);
                href_d  = in_href;
                data_d  = in_href ? pix_byte : 8'h00;
                // Bar counter steps once per pixel, after its low byte.
                if (in_href && byte_cnt_q[0]) begin
                    if (bar_px_q == BAR_LAST) begin
                        bar_px_d  = 9'd0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_px_d  = bar_px_q + 9'd1;
                    end
                end
                if (byte_cnt_q == BYTE_LAST) begin
                    byte_cnt_d = '0;
                    bar_idx_d  = bar_start;
                    bar_px_d   = px_start;
                    if (line_cnt_q == line_last) begin
                        line_cnt_d = '0;
                        case (state_q)
                            S_VSYNC:  state_d = S_VBP;
                            S_VBP:    state_d = S_ACTIVE;
                            S_ACTIVE: state_d = S_VFP;
                            default: begin
                                frame_cnt_d = frame_cnt_q + 8'd1;
`ifdef OV7670_STREAM_SCROLL_EN
                                // frame_cnt wrapping to 0 also brings the scroll origin back to 0.
                                if (frame_cnt_q == 8'hFF) begin
                                    scroll_x_d   = 9'd0;
                                    scroll_bar_d = 3'd0;
                                    scroll_px_d  = 9'd0;
                                end else begin
                                    scroll_x_d   = sx2;
                                    scroll_bar_d = sbar2;
                                    scroll_px_d  = spx2;
                                end
`endif
                                if (run) begin
                                    state_d = S_VSYNC;
                                    pat_d   = pattern_sel;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end
                        endcase
                    end else begin
                        line_cnt_d = line_cnt_q + LCW'(1);
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                end
            end
        end
        pclk_d = (div_cnt_d >= DIV_HALF);
        busy_d = (state_d != S_IDLE);
    end

    // State registers; reset returns everything to IDLE with a silent bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            line_cnt_q  <= '0;
            pat_q       <= 2'd0;
            frame_cnt_q <= 8'd0;
            bar_idx_q   <= 3'd0;
            bar_px_q    <= 9'd0;
            pclk_q      <= 1'b0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
`ifdef OV7670_STREAM_SCROLL_EN
            scroll_x_q   <= 9'd0;
            scroll_bar_q <= 3'd0;
            scroll_px_q  <= 9'd0;
`endif
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            line_cnt_q  <= line_cnt_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            bar_idx_q   <= bar_idx_d;
            bar_px_q    <= bar_px_d;
            pclk_q      <= pclk_d;
            href_q      <= href_d;
            vsync_q     <= vsync_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
`ifdef OV7670_STREAM_SCROLL_EN
            scroll_x_q   <= scroll_x_d;
            scroll_bar_q <= scroll_bar_d;
            scroll_px_q  <= scroll_px_d;
`endif
        end
    end

    assign ov_pclk   = pclk_q;
    assign ov_href   = href_q;
    assign ov_vsync  = vsync_q;
    assign ov_data   = data_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen on a shrunken frame (32x20 active, DIV=4).
// Captures every href byte per frame, checks line/frame structure, pclk-relative timing,
// run drop/reassert, mid-frame pattern change and asynchronous reset.
module tb_ov7670_stream_gen;

    localparam int DIV      = 4;
    localparam int H_ACTIVE = 32;
    localparam int H_BLANK  = 8;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 2;
    localparam int V_ACTIVE = 20;
    localparam int V_FP     = 2;
    localparam int LB       = 2 * H_ACTIVE + H_BLANK;   // 72 slots per line
    localparam int NV       = 19;

`ifdef OV7670_STREAM_SCROLL_EN
    localparam int GR0 = 'h0027;
    localparam int GR1 = 'h0898;
    localparam int GR2 = 'h0003;
`else
    localparam int GR0 = 'h0023;
    localparam int GR1 = 'h0894;
    localparam int GR2 = 'h081F;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [1:0] pattern_sel;
    logic       ov_pclk, ov_href, ov_vsync, busy;
    logic [7:0] ov_data, frame_cnt;

    ov7670_stream_gen #(
        .DIV(DIV), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .pattern_sel(pattern_sel),
        .ov_pclk(ov_pclk), .ov_href(ov_href), .ov_vsync(ov_vsync),
        .ov_data(ov_data), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Frame capture and structure monitor, sampled on the falling clk edge.
    logic [7:0] cap [0:3][0:19][0:63];
    int   fidx = -1;
    int   cur_line = -1;
    int   hlen = 0;
    int   slot_no = 0;
    int   vs_len [4];
    int   href_off [4];
    int   hcnt [4];
    int   hbad [4];
    logic last_href = 1'b0, last_vsync = 1'b0;
    logic prev_pclk = 1'b0, prev_href = 1'b0, prev_vsync = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int   hi_cnt = 0;
    int   stab_err = 0;
    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (ov_pclk && !prev_pclk) begin
            slot_no++;
            if (ov_vsync && !last_vsync) begin
                fidx++;
                cur_line = -1;
                slot_no  = 0;
            end
            if (fidx >= 0 && fidx < 4) begin
                if (ov_vsync) vs_len[fidx]++;
                if (ov_href && !last_href) begin
                    cur_line++;
                    hlen = 0;
                    if (hcnt[fidx] == 0) href_off[fidx] = slot_no;
                    hcnt[fidx]++;
                end
                if (ov_href) begin
                    if (cur_line >= 0 && cur_line < 20 && hlen < 64)
                        cap[fidx][cur_line][hlen] = ov_data;
                    hlen++;
                end
                if (!ov_href && last_href && hlen != 2 * H_ACTIVE) hbad[fidx]++;
            end
            last_href  = ov_href;
            last_vsync = ov_vsync;
        end
        // Bus may only change as pclk falls, and pclk must be high for DIV/2 cycles.
        if (chk_en) begin
            if ({ov_href, ov_vsync, ov_data} != {prev_href, prev_vsync, prev_data} &&
                !(prev_pclk && !ov_pclk))
                stab_err++;
            if (prev_pclk && !ov_pclk && hi_cnt != DIV / 2) stab_err++;
        end
        if (ov_pclk) hi_cnt = prev_pclk ? hi_cnt + 1 : 1;
        prev_pclk  = ov_pclk;
        prev_href  = ov_href;
        prev_vsync = ov_vsync;
        prev_data  = ov_data;
    end

    task automatic wait_line(input int f, input int ln, input string name);
        int n = 0;
        while (!(fidx == f && cur_line >= ln) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (fidx == f && cur_line >= ln) ? 1 : 0, 1);
    endtask

    typedef struct {
        int f;
        int y;
        int x;
        int pix;
    } vec_t;

    vec_t vt [NV];

    initial begin
        int n;
        // frame 0: colour bars (4 px per bar), pattern change at y=10 ignored
        vt[0]  = '{0, 0, 0, 'hFFFF};
        vt[1]  = '{0, 0, 4, 'hFFE0};
        vt[2]  = '{0, 5, 3, 'hFFFF};
        vt[3]  = '{0, 5, 8, 'h07FF};
        vt[4]  = '{0, 12, 15, 'h07E0};
        vt[5]  = '{0, 19, 16, 'hF81F};
        vt[6]  = '{0, 19, 27, 'h001F};
        vt[7]  = '{0, 19, 28, 'h0000};
        vt[8]  = '{0, 3, 31, 'h0000};
        // frame 1: checker
        vt[9]  = '{1, 16, 0, 'hFFFF};
        vt[10] = '{1, 0, 0, 'h0000};
        vt[11] = '{1, 0, 16, 'hFFFF};
        vt[12] = '{1, 0, 13, 'h0000};
        vt[13] = '{1, 16, 20, 'h0000};
        // frame 2: gradient
        vt[14] = '{2, 5, 3, GR0};
        vt[15] = '{2, 17, 20, GR1};
        vt[16] = '{2, 0, 31, GR2};
        // frame 3: solid with frame_cnt = 3
        vt[17] = '{3, 0, 0, 'h0303};
        vt[18] = '{3, 4, 31, 'h0303};

        reset = 1'b1;
        run = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_pclk", ov_pclk, 0);
        chk("rst_href", ov_href, 0);
        chk("rst_vsync", ov_vsync, 0);
        chk("rst_data", ov_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);

        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk_en = 1'b1;
        run = 1'b1;

        wait_line(0, 10, "reach_f0_y10");
        chk("f0_frame_cnt", frame_cnt, 0);
        chk("f0_busy", busy, 1);
        pattern_sel = 2'd2;

        wait_line(1, 10, "reach_f1_y10");
        chk("f1_frame_cnt", frame_cnt, 1);
        run = 1'b0;

        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("run_drop_idle", busy, 0);
        chk("run_drop_frame_cnt", frame_cnt, 2);
        chk("idle_pclk", ov_pclk, 0);
        chk("idle_href", ov_href, 0);
        chk("idle_vsync", ov_vsync, 0);
        chk("idle_data", ov_data, 0);
        repeat (100) @(negedge clk);
        chk("idle_stays_busy", busy, 0);
        chk("idle_no_new_frame", fidx, 1);

        pattern_sel = 2'd1;
        run = 1'b1;
        n = 0;
        while (!ov_vsync && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("vsync_restart_latency", (n >= 1 && n <= DIV + 1) ? 1 : 0, 1);

        wait_line(2, 10, "reach_f2_y10");
        pattern_sel = 2'd3;

        wait_line(3, 5, "reach_f3_y5");
        chk("f3_frame_cnt", frame_cnt, 3);
        chk_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_rst_pclk", ov_pclk, 0);
        chk("async_rst_href", ov_href, 0);
        chk("async_rst_vsync", ov_vsync, 0);
        chk("async_rst_data", ov_data, 0);
        chk("async_rst_frame_cnt", frame_cnt, 0);
        chk("async_rst_busy", busy, 0);
        repeat (4) @(negedge clk);
        run = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", busy, 0);

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("pix_f%0d_y%0d_x%0d", vt[i].f, vt[i].y, vt[i].x),
                int'({cap[vt[i].f][vt[i].y][2 * vt[i].x], cap[vt[i].f][vt[i].y][2 * vt[i].x + 1]}),
                vt[i].pix);
        end

        for (int f = 0; f < 3; f++) begin
            chk($sformatf("vsync_slots_f%0d", f), vs_len[f], V_SYNC * LB);
            chk($sformatf("first_href_slot_f%0d", f), href_off[f], (V_SYNC + V_BP) * LB);
            chk($sformatf("href_pulses_f%0d", f), hcnt[f], V_ACTIVE);
            chk($sformatf("href_bad_len_f%0d", f), hbad[f], 0);
        end
        chk("pclk_relative_timing_errors", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
